// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access controller.
//   state_t   : controller sequencing states
//   DEF_*     : default geometry and timing values
//   cnt_width : width of the phase down-counter for a given timing set
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACCESS,
        SENSE,
        RECOVER
    } state_t;

    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_ROWS    = 128;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_T_PRE   = 1;
    localparam int DEF_T_WL    = 2;
    localparam int DEF_T_SENSE = 1;

    // The counter only has to hold (longest phase - 1); keep at least one bit
    // so the register exists even when every phase is a single cycle.
    function automatic int cnt_width(input int t_pre, input int t_wl, input int t_sense);
        int m;
        m = t_pre;
        if (t_wl > m) m = t_wl;
        if (t_sense > m) m = t_sense;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// Row address to one-hot wordline decoder (combinational).
//   addr   : row address
//   en     : decode enable; all outputs low when 0
//   row_oh : one-hot row select, all zeros when disabled or addr >= ROWS
module sram_row_decoder
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROWS   = DEF_ROWS
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [ROWS-1:0]   row_oh
);

    // Comparing against every implemented row makes out-of-range addresses
    // fall out naturally as an all-zero vector.
    always_comb begin
        row_oh = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_oh[r] = en && (addr == ADDR_W'(r));
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Wordline / bitline timing controller in front of a 6T SRAM array.
// Accepts one read or write at a time over valid/ready and sequences
// precharge, wordline, write drivers and sense amps; read data is captured
// from the sense amps into a registered response.
//   clk, rst_n               : clock, synchronous active-low reset
//   req_valid/req_ready      : request handshake (req_ready registered)
//   req_we/req_addr/req_wdata: request fields
//   rsp_valid/rsp_rdata      : single-cycle read response, data held
//   wl, pre_n, write_en, sense_en, wdrv_en, wdrv_data : array controls
//   sa_out                   : sense-amp outputs
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bitlines precharging, wordlines low, ready for a request
// PRE     | precharge for T_PRE cycles after accept
// ACCESS  | wordline high for T_WL cycles; write drivers on for writes
// SENSE   | read only: wordline held, sense amps on for T_SENSE cycles
// RECOVER | wordline and enables low, precharge off, one cycle
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROWS    = DEF_ROWS,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int T_PRE   = DEF_T_PRE,
    parameter int T_WL    = DEF_T_WL,
    parameter int T_SENSE = DEF_T_SENSE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic [ROWS-1:0]   wl,
    output logic              pre_n,
    output logic              write_en,
    output logic              sense_en,
    output logic              wdrv_en,
    output logic [WIDTH-1:0]  wdrv_data,
    input  logic [WIDTH-1:0]  sa_out
);

    localparam int CNT_W = cnt_width(T_PRE, T_WL, T_SENSE);
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(T_WL - 1);
    localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(T_SENSE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_rdata_q;
    logic [ROWS-1:0]    wl_q;
    logic               pre_n_q;
    logic               write_en_q;
    logic               sense_en_q;
    logic               wdrv_en_q;
    logic [WIDTH-1:0]   wdrv_data_q;
    logic [ROWS-1:0]    wl_d;

    // Decoded row is only consumed on the PRE -> ACCESS edge.
    sram_row_decoder #(
        .ADDR_W (ADDR_W),
        .ROWS   (ROWS)
    ) u_row_decoder (
        .addr   (addr_q),
        .en     (state_q == PRE),
        .row_oh (wl_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wl_q        <= '0;
            pre_n_q     <= 1'b0;
            write_en_q  <= 1'b0;
            sense_en_q  <= 1'b0;
            wdrv_en_q   <= 1'b0;
            wdrv_data_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        cnt_q       <= PRE_LD;
                        state_q     <= PRE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt_q == '0) begin
                        pre_n_q     <= 1'b1;
                        wl_q        <= wl_d;
                        write_en_q  <= we_q;
                        wdrv_en_q   <= we_q;
                        wdrv_data_q <= we_q ? wdata_q : '0;
                        cnt_q       <= WL_LD;
                        state_q     <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        write_en_q  <= 1'b0;
                        wdrv_en_q   <= 1'b0;
                        wdrv_data_q <= '0;
                        if (we_q) begin
                            wl_q    <= '0;
                            state_q <= RECOVER;
                        end else begin
                            sense_en_q <= 1'b1;
                            cnt_q      <= SENSE_LD;
                            state_q    <= SENSE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                SENSE: begin
                    if (cnt_q == '0) begin
                        // With no wordline raised the sense amps resolve noise,
                        // so out-of-range reads return zero instead.
                        rsp_rdata_q <= (|wl_q) ? sa_out : '0;
                        rsp_valid_q <= 1'b1;
                        sense_en_q  <= 1'b0;
                        wl_q        <= '0;
                        state_q     <= RECOVER;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RECOVER: begin
                    pre_n_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wl        = wl_q;
    assign pre_n     = pre_n_q;
    assign write_en  = write_en_q;
    assign sense_en  = sense_en_q;
    assign wdrv_en   = wdrv_en_q;
    assign wdrv_data = wdrv_data_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two configurations (default timing with 128
// rows, and 100 rows with T_PRE=3/T_WL=1/T_SENSE=2), each with an attached
// cell-array model, a cycle-based reference model and a per-cycle compare.
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int R  = (g == 0) ? 128 : 100;
        localparam int TP = (g == 0) ? 1 : 3;
        localparam int TW = (g == 0) ? 2 : 1;
        localparam int TS = (g == 0) ? 1 : 2;
        // Hand-computed: read latency, back-to-back read spacing, row-120 read data
        localparam int EXP_LAT = (g == 0) ? 5 : 7;
        localparam int EXP_GAP = (g == 0) ? 6 : 8;
        localparam logic [31:0] EXP_R120 = (g == 0) ? 32'h1234_5678 : 32'h0;

        logic        rst_n, req_valid, req_ready, req_we;
        logic [6:0]  req_addr;
        logic [31:0] req_wdata, rsp_rdata, wdrv_data, sa_out;
        logic        rsp_valid, pre_n, write_en, sense_en, wdrv_en;
        logic [R-1:0] wl;

        sram_access_ctrl #(
            .ADDR_W(7), .ROWS(R), .WIDTH(32), .T_PRE(TP), .T_WL(TW), .T_SENSE(TS)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
            .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wl(wl), .pre_n(pre_n),
            .write_en(write_en), .sense_en(sense_en), .wdrv_en(wdrv_en),
            .wdrv_data(wdrv_data), .sa_out(sa_out)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        // Cell array: a selected row takes the driver data at an edge where the
        // controller is out of reset; sense amps show garbage unless a row is
        // selected while sensing.
        logic [31:0] mem [R];
        initial begin
            for (int r = 0; r < R; r++) mem[r] = 32'h1000_0000 + 32'(r * 3);
            forever begin
                @(posedge clk);
                if (rst_n && write_en && wdrv_en)
                    for (int r = 0; r < R; r++) if (wl[r]) mem[r] = wdrv_data;
            end
        end
        always_comb begin
            sa_out = 32'hBAD0_5A5A;
            for (int r = 0; r < R; r++) if (sense_en && wl[r]) sa_out = mem[r];
        end

        // Reference model: m_k is the cycle number since the accept edge.
        int          cyc = 0;
        bit          m_live = 1'b0, m_busy = 1'b0, m_ready = 1'b0, m_we = 1'b0;
        int          m_k = 0, m_addr = 0;
        logic [31:0] m_wdata = '0, m_pend = '0, m_rdata = '0;
        logic [31:0] ref_mem [128];

        function automatic int occ(input bit we);
            return TP + TW + (we ? 0 : TS) + 2;
        endfunction

        initial begin
            for (int r = 0; r < 128; r++) ref_mem[r] = 32'h1000_0000 + 32'(r * 3);
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst_n) begin
                    m_busy = 0; m_ready = 0; m_k = 0; m_rdata = '0;
                end else if (m_busy) begin
                    m_k++;
                    if (!m_we && m_k == TP + TW + TS + 1) m_rdata = m_pend;
                    if (m_k == occ(m_we)) begin
                        m_busy = 0; m_ready = 1;
                        if (m_we && m_addr < R) ref_mem[m_addr] = m_wdata;
                    end
                end else if (m_ready && req_valid) begin
                    m_busy = 1; m_ready = 0; m_k = 1;
                    m_we = req_we; m_addr = int'(req_addr); m_wdata = req_wdata;
                    m_pend = (m_addr < R) ? ref_mem[m_addr] : '0;
                end else begin
                    m_ready = 1;
                end
                m_live = 1;
            end
        end

        // Per-cycle compare against the model, plus array-level invariants.
        logic [R-1:0] e_wl;
        logic [31:0]  e_wdata;
        bit           e_pre_n, e_we, e_se, e_drv, e_rv;
        initial begin
            forever begin
                @(negedge clk);
                if (m_live) begin
                    e_wl = '0; e_wdata = '0;
                    e_pre_n = 0; e_we = 0; e_se = 0; e_drv = 0; e_rv = 0;
                    if (m_busy && m_k > TP) begin
                        e_pre_n = 1;
                        if (m_k <= TP + TW) begin
                            if (m_addr < R) e_wl[m_addr] = 1'b1;
                            e_we = m_we; e_drv = m_we;
                            e_wdata = m_we ? m_wdata : '0;
                        end else if (!m_we && m_k <= TP + TW + TS) begin
                            if (m_addr < R) e_wl[m_addr] = 1'b1;
                            e_se = 1;
                        end else begin
                            e_rv = !m_we;
                        end
                    end
                    chk(nm("req_ready"), 128'(req_ready), 128'(m_ready));
                    chk(nm("pre_n"), 128'(pre_n), 128'(e_pre_n));
                    chk(nm("wl"), 128'(wl), 128'(e_wl));
                    chk(nm("write_en"), 128'(write_en), 128'(e_we));
                    chk(nm("sense_en"), 128'(sense_en), 128'(e_se));
                    chk(nm("wdrv_en"), 128'(wdrv_en), 128'(e_drv));
                    chk(nm("wdrv_data"), 128'(wdrv_data), 128'(e_wdata));
                    chk(nm("rsp_valid"), 128'(rsp_valid), 128'(e_rv));
                    chk(nm("rsp_rdata"), 128'(rsp_rdata), 128'(m_rdata));
                    chk(nm("inv_onehot0"), 128'($onehot0(wl)), 128'(1));
                    chk(nm("inv_wl_pre"), 128'((wl == '0) || pre_n), 128'(1));
                    chk(nm("inv_we_se"), 128'(write_en && sense_en), 128'(0));
                    chk(nm("inv_drv_we"), 128'(!wdrv_en || write_en), 128'(1));
                end
            end
        end

        // Called at a negedge; returns at the negedge after the accept edge.
        task automatic send(input bit we, input int addr, input logic [31:0] d,
                            input bit keep, output int acc);
            req_we = we; req_addr = 7'(addr); req_wdata = d; req_valid = 1'b1;
            acc = -1;
            for (int n = 0; n < 100 && acc < 0; n++) begin
                if (req_ready) acc = cyc + 1;
                @(negedge clk);
            end
            if (!keep) req_valid = 1'b0;
            chk(nm("accept_seen"), 128'(acc >= 0), 128'(1));
        endtask

        task automatic wait_rsp(output int lat);
            lat = -1;
            for (int n = 1; n <= 60 && lat < 0; n++) begin
                if (rsp_valid) lat = n;
                else @(negedge clk);
            end
        endtask

        initial begin
            int a1, a2, lat;
            bit found;
            rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk(nm("ready_after_reset"), 128'(req_ready), 128'(1));

            send(1'b1, 5, 32'hDEAD_BEEF, 1'b0, a1);
            send(1'b1, 120, 32'h1234_5678, 1'b0, a1);
            send(1'b0, 5, 32'h0, 1'b0, a1);
            wait_rsp(lat);
            chk(nm("read_latency"), 128'(lat), 128'(EXP_LAT));
            chk(nm("read_row5"), 128'(rsp_rdata), 128'(32'hDEAD_BEEF));

            send(1'b0, 0, 32'h0, 1'b1, a1);
            send(1'b0, 127, 32'h0, 1'b0, a2);
            chk(nm("b2b_gap"), 128'(a2 - a1), 128'(EXP_GAP));
            wait_rsp(lat);
            chk(nm("b2b_latency"), 128'(lat), 128'(EXP_LAT));

            send(1'b0, 120, 32'h0, 1'b0, a1);
            wait_rsp(lat);
            chk(nm("row120_latency"), 128'(lat), 128'(EXP_LAT));
            chk(nm("row120_data"), 128'(rsp_rdata), 128'(EXP_R120));

            // Abort a write in its first wordline cycle.
            send(1'b1, 5, 32'h0BAD_F00D, 1'b0, a1);
            found = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                if (wl != '0) found = 1'b1;
                else @(negedge clk);
            end
            chk(nm("access_seen"), 128'(found), 128'(1));
            rst_n = 1'b0;
            @(negedge clk);
            chk(nm("abort_wl"), 128'(wl), 128'(0));
            chk(nm("abort_write_en"), 128'(write_en), 128'(0));
            rst_n = 1'b1;
            send(1'b0, 5, 32'h0, 1'b0, a1);
            wait_rsp(lat);
            chk(nm("abort_keeps_data"), 128'(rsp_rdata), 128'(32'hDEAD_BEEF));

            for (int i = 0; i < 1500; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), $urandom,
                     ($urandom_range(0, 3) == 0), a1);
            end
            req_valid = 1'b0;
            repeat (20) @(negedge clk);
            n_done++;
        end
    end

    initial begin
        fork
            wait (n_done == 2);
            #2_000_000;
        join_any
        checks++;
        if (n_done != 2) begin
            errors++;
            $display("FAIL global_timeout: done=%0d expected 2", n_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
